// File: rtl/mema_row_loader.sv
// Row loader feeding the memA skew buffer. It assembles row-major A elements into DIM-wide rows,
// strobes each row into memA, then holds the shift enable for the full skewed-drain window.
module mema_row_loader #(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [BITS_AB-1:0]  in_data,
  output logic signed [BITS_AB-1:0]  Ain [DIM-1:0],
  output logic [$clog2(DIM)-1:0]     Arow,
  output logic                       WrEn,
  output logic                       en,
  output logic                       busy,
  output logic                       done
);

  localparam int CW = $clog2(DIM);
  localparam int DW = $clog2(3*DIM-2);
  localparam logic [CW-1:0] LAST_IDX = CW'(DIM-1);
  localparam logic [DW-1:0] LAST_DRAIN = DW'(3*DIM-3);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WRITE = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                     state_q, state_d;
  logic [CW-1:0]              col_q, col_d;
  logic [CW-1:0]              row_q, row_d;
  logic [DW-1:0]              dcnt_q, dcnt_d;
  logic signed [BITS_AB-1:0]  ain_q [DIM-1:0];
  logic signed [BITS_AB-1:0]  ain_d [DIM-1:0];
  logic                       in_ready_q, in_ready_d;
  logic                       wren_q, wren_d;
  logic                       en_q, en_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       handshake;

  assign handshake = in_valid && in_ready_q;

  // Next-state, counter and row-assembly logic; outputs are derived from the next state so they register cleanly.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    dcnt_d  = dcnt_q;
    ain_d   = ain_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          col_d   = '0;
          row_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (handshake) begin
          ain_d[col_q] = in_data;
          if (col_q == LAST_IDX) begin
            col_d   = '0;
            state_d = S_WRITE;
          end else begin
            col_d = col_q + 1'b1;
          end
        end else begin
          state_d = S_LOAD;
        end
      end
      S_WRITE: begin
        if (row_q == LAST_IDX) begin
          state_d = S_DRAIN;
          dcnt_d  = '0;
        end else begin
          row_d   = row_q + 1'b1;
          state_d = S_LOAD;
        end
      end
      S_DRAIN: begin
        dcnt_d = dcnt_q + 1'b1;
        if (dcnt_q == LAST_DRAIN) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d == S_LOAD);
    wren_d     = (state_d == S_WRITE);
    en_d       = (state_d == S_DRAIN);
    done_d     = (state_d == S_DONE);
    busy_d     = (state_d != S_IDLE);
  end

  // State, counters, row buffer and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      col_q      <= '0;
      row_q      <= '0;
      dcnt_q     <= '0;
      in_ready_q <= 1'b0;
      wren_q     <= 1'b0;
      en_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      for (int i = 0; i < DIM; i++) begin
        ain_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      dcnt_q     <= dcnt_d;
      in_ready_q <= in_ready_d;
      wren_q     <= wren_d;
      en_q       <= en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ain_q      <= ain_d;
    end
  end

  assign Ain      = ain_q;
  assign Arow     = row_q;
  assign WrEn     = wren_q;
  assign en       = en_q;
  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: doc/mema_row_loader.md
# mema_row_loader

Sequencer directly upstream of the A-operand skew buffer (memA) in the systolic matrix-multiply datapath. It accepts A-matrix elements one at a time in row-major order over a valid/ready stream and assembles each row into a DIM-wide vector. It writes each completed row into the buffer with a one-cycle `WrEn` pulse and the matching `Arow` index. Once all DIM rows are loaded, it asserts `en` for the full skewed-drain window so every buffered element reaches the array, then signals `done`.

## Interface
Parameters:
- `BITS_AB`, 8: signed element width; must match memA.
- `DIM`, 8: matrix dimension, ≥2; must match memA.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin loading a new matrix; sampled only in IDLE.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  loader accepts `in_data` this cycle.
- `in_data`  in  BITS_AB signed  next A element, row-major.
- `Ain`  out  DIM×BITS_AB signed (unpacked [DIM-1:0])  assembled row; connects to memA `Ain`.
- `Arow`  out  $clog2(DIM)  target row index; connects to memA `Arow`.
- `WrEn`  out  1  row write strobe to memA.
- `en`  out  1  shift enable to memA.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.

## Operation
- State machine: IDLE, LOAD, WRITE, DRAIN, DONE.
- IDLE:
  - `in_ready`=0.
  - On `start`=1: go to LOAD; clear `col` and `row`.
- LOAD:
  - `in_ready`=1.
  - On handshake (`in_valid & in_ready`): `Ain[col] <= in_data`, then `col++`.
  - Handshake with `col==DIM-1`: `col` wraps to 0; go to WRITE.
  - Without `in_valid`, stay in LOAD. `Ain` and counters hold.
- WRITE (exactly one cycle):
  - `WrEn`=1, `Arow`=`row`, `in_ready`=0. `Ain` holds the complete row.
  - If `row==DIM-1`: go to DRAIN and clear `dcnt`.
  - Otherwise: `row++`, return to LOAD.
- DRAIN:
  - `en`=1 every cycle; `dcnt++`.
  - After 3·DIM−2 cycles (`dcnt==3·DIM−3`): go to DONE.
  - The drain counter is $clog2(3·DIM−2) bits wide.
- DONE: `done`=1 for one cycle, then IDLE.
- Element `k` of the stream lands at row k/DIM, column k%DIM. No arithmetic is performed on data; elements pass bit-exact.
- `Arow` is the registered `row` in all states. `WrEn` is the only qualifier memA uses.
- `start` in any state other than IDLE is ignored.
- `in_valid` while `in_ready`=0 is ignored; that element is not consumed.
- `WrEn` and `en` are never high in the same cycle.

## Timing
- Reset values: state=IDLE; `Ain` all 0; `Arow`=0; `WrEn`=0; `en`=0; `in_ready`=0; `busy`=0; `done`=0; `col`=`row`=`dcnt`=0.
- `rst` mid-operation returns to IDLE on the next edge. Partially assembled rows are discarded and no `WrEn` is issued. `rst` has priority over every transition.
- All outputs are registered or decoded from registered state only. There is no combinational path from `in_valid` or `start` to any output.
- `start` at cycle T puts the block in LOAD at T+1.
- Each row occupies DIM accepting cycles plus 1 WRITE cycle.
- With `in_valid` held high, for DIM=8: WrEn pulses at T+9, T+18, …, T+72.
- DRAIN runs T+73..T+94; `done` is high at T+95 and the block is back in IDLE at T+96.
- Stalls on `in_valid` extend LOAD cycle-for-cycle. Row order and WrEn spacing are otherwise unchanged.
- `start` held high through DONE re-launches on the first IDLE cycle (T+96 sampled, LOAD at T+97).

## Test plan
- Reset: assert `rst` for 2 cycles → all outputs 0, `busy`=0.
- Full load, DIM=8, element k = k−64 (signed), `in_valid` constant → exactly 8 WrEn pulses at T+9·(r+1) with Arow=r, Ain[c]=8r+c−64, then 22 `en` cycles, then `done` at T+95.
- Random `in_valid` gaps (≈30% idle) → same Ain/Arow contents per WrEn, exactly 64 accepted elements, exactly 22 `en` cycles, a single `done` pulse.
- Mid-load reset: `rst` after 20 accepted elements → IDLE next cycle, no further WrEn. A new `start` reloads correctly from row 0.
- Ignored controls: `start` pulsed during LOAD and DRAIN, and `in_valid` during WRITE/DRAIN → no state change and no extra element consumed.
- DIM=2, BITS_AB=4 with elements −8, 7, 0, −1 → WrEn rows {−8,7} then {0,−1}, 4 `en` cycles, then `done`.
